// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller.
// Optional breakpoint support is enabled by defining CPU_CLK_BREAKPOINT_EN.
package cpu_clk_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [2:0] {
    S_HALT     = 3'd0,
    S_RUN_SLOW = 3'd1,
    S_RUN_FAST = 3'd2,
    S_STEP     = 3'd3
`ifdef CPU_CLK_BREAKPOINT_EN
    ,
    S_BP       = 3'd4
`endif
  } state_e;

  function automatic state_e mode_to_state(input logic [1:0] mode);
    state_e st;
    case (mode)
      MODE_SLOW: st = S_RUN_SLOW;
      MODE_FAST: st = S_RUN_FAST;
      MODE_STEP: st = S_STEP;
      default:   st = S_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-cycle press pulse.
// Unaffected by CPU_CLK_BREAKPOINT_EN.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = cpu_clk_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;
  logic          rise_reg;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg   <= '0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      rise_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn_i};
      rise_reg <= 1'b0;
      if (sync_reg[1] == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        stable_reg <= sync_reg[1];
        cnt_reg    <= '0;
        rise_reg   <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign rise_o = rise_reg;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable generator for the single-cycle CPU: halt, run-slow, run-fast, single-step.
// Define CPU_CLK_BREAKPOINT_EN to add the PC breakpoint ports and the S_BP state.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             slow_clk_i,
  input  logic             step_btn_i,
  input  logic [1:0]       mode_i,
  input  logic             halt_i,
`ifdef CPU_CLK_BREAKPOINT_EN
  input  logic [31:0]      pc_i,
  input  logic [31:0]      bp_addr_i,
  input  logic             bp_valid_i,
  output logic             bp_hit_o,
`endif
  output logic             cpu_en_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [2:0]       state_o
);

  logic [2:0]       slow_sync_reg;
  logic             slow_tick;
  logic             step_req;
  state_e           state_reg, state_next;
  logic             en_reg, en_next;
  logic [CNT_W-1:0] cnt_reg;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .btn_i (step_btn_i),
    .rise_o(step_req)
  );

  // Two sync stages plus one history stage for the rising-edge compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slow_sync_reg <= '0;
    end else begin
      slow_sync_reg <= {slow_sync_reg[1:0], slow_clk_i};
    end
  end

  assign slow_tick = slow_sync_reg[1] & ~slow_sync_reg[2];

`ifdef CPU_CLK_BREAKPOINT_EN
  logic        bp_block_reg;
  logic [31:0] bp_pc_reg;
  logic        bp_match;

  // After leaving S_BP the PC that caused the stop is masked until it moves on.
  assign bp_match = bp_valid_i && (pc_i == bp_addr_i) &&
                    !(bp_block_reg && (pc_i == bp_pc_reg));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bp_block_reg <= 1'b0;
      bp_pc_reg    <= '0;
    end else if (state_reg == S_BP && state_next != S_BP) begin
      bp_block_reg <= 1'b1;
      bp_pc_reg    <= pc_i;
    end else if (pc_i != bp_pc_reg) begin
      bp_block_reg <= 1'b0;
    end
  end

  assign bp_hit_o = (state_reg == S_BP);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_HALT;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      en_reg    <= en_next;
    end
  end

  always_comb begin
    state_next = mode_to_state(mode_i);
    en_next    = 1'b0;
    case (state_reg)
      S_RUN_FAST: en_next = 1'b1;
      S_RUN_SLOW: en_next = slow_tick;
      S_STEP:     en_next = step_req;
      default:    en_next = 1'b0;
    endcase
`ifdef CPU_CLK_BREAKPOINT_EN
    if (state_reg == S_BP) begin
      state_next = S_BP;
      if (step_req) begin
        en_next    = 1'b1;
        state_next = mode_to_state(mode_i);
      end else if (!bp_valid_i) begin
        state_next = mode_to_state(mode_i);
      end
    end else if (bp_match && (state_reg == S_RUN_SLOW || state_reg == S_RUN_FAST)) begin
      state_next = S_BP;
      en_next    = 1'b0;
    end
`endif
    // Forced halt overrides everything and swallows any coincident tick or step.
    if (halt_i) begin
      state_next = S_HALT;
      en_next    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (en_reg) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cpu_en_o    = en_reg;
  assign cycle_cnt_o = cnt_reg;
  assign state_o     = state_reg;

endmodule
